// File: rtl/rate_div_pkg.sv
// Shared constants and elaboration-time helpers for the multi-rate divider.
package rate_div_pkg;

  localparam int   DEF_CNT_W     = 29;
  localparam logic CFG_IMMEDIATE = 1'b0;
  localparam logic CFG_DEFER     = 1'b1;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) begin
      r++;
    end
    return r;
  endfunction

  // A single channel still needs a one-bit select so the config port keeps a width.
  function automatic int ch_width(input int n);
    return (n > 1) ? clog2(n) : 1;
  endfunction

endpackage

// File: rtl/multi_rate_divider_if.sv
// Config write port: valid/ready handshake carrying channel, divisor and defer flag.
interface multi_rate_divider_if
  import rate_div_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = DEF_CNT_W
);
  localparam int CH_W = ch_width(NUM_CH);

  logic             iCfgValid;
  logic             oCfgReady;
  logic [CH_W-1:0]  iCfgCh;
  logic [CNT_W-1:0] iCfgDiv;
  logic             iCfgDefer;
  logic             oCfgErr;

  modport master (
    output iCfgValid, iCfgCh, iCfgDiv, iCfgDefer,
    input  oCfgReady, oCfgErr
  );

  modport slave (
    input  iCfgValid, iCfgCh, iCfgDiv, iCfgDefer,
    output oCfgReady, oCfgErr
  );

endinterface

// File: rtl/rate_div_channel.sv
// One programmable divider: down-counter with reload, enable pulse and square wave,
// plus a pending divisor that takes effect at the next terminal count.
module rate_div_channel
  import rate_div_pkg::*;
#(
  parameter int               CNT_W     = DEF_CNT_W,
  parameter logic [CNT_W-1:0] RESET_DIV = '0
) (
  input  logic             iClock,
  input  logic             iReset,
  input  logic             iRun,
  input  logic             iSync,
  input  logic             iWrEn,
  input  logic             iWrDefer,
  input  logic [CNT_W-1:0] iWrDiv,
  output logic             oEnable,
  output logic             oWave
);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] div;
  logic [CNT_W-1:0] pend;
  logic [CNT_W-1:0] eff;
  logic             pendVld;

  assign eff = pendVld ? pend : div;

  // Reload value for a divisor; an off divisor parks the counter at zero.
  function automatic logic [CNT_W-1:0] reloadOf(input logic [CNT_W-1:0] n);
    return (n == '0) ? '0 : n - CNT_W'(1);
  endfunction

  always_ff @(posedge iClock) begin
    if (iReset) begin
      cnt     <= '0;
      div     <= RESET_DIV;
      pend    <= RESET_DIV;
      pendVld <= 1'b0;
      oEnable <= 1'b0;
      oWave   <= 1'b0;
    end else if (iSync) begin
      div     <= eff;
      pendVld <= 1'b0;
      cnt     <= reloadOf(eff);
      oEnable <= 1'b0;
      oWave   <= 1'b0;
    end else if (iWrEn && iWrDefer == CFG_IMMEDIATE) begin
      div     <= iWrDiv;
      cnt     <= reloadOf(iWrDiv);
      pendVld <= 1'b0;
      oEnable <= 1'b0;
    end else begin
      if (iRun && div != '0) begin
        if (cnt == '0) begin
          cnt     <= reloadOf(eff);
          div     <= eff;
          pendVld <= 1'b0;
          oEnable <= 1'b1;
          oWave   <= ~oWave;
        end else begin
          cnt     <= cnt - CNT_W'(1);
          oEnable <= 1'b0;
        end
      end else begin
        oEnable <= 1'b0;
      end
      // A deferred write on a terminal-count edge must survive that reload,
      // so it is assigned after the count logic.
      if (iWrEn) begin
        pend    <= iWrDiv;
        pendVld <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/multi_rate_divider.sv
// NUM_CH independent rate dividers sharing one clock, run and sync; the top decodes
// config writes to a channel and flags writes aimed at a channel that does not exist.
module multi_rate_divider
  import rate_div_pkg::*;
#(
  parameter int          NUM_CH    = 4,
  parameter int          CNT_W     = DEF_CNT_W,
  parameter int unsigned RESET_DIV = 0
) (
  input  logic               iClock,
  input  logic               iReset,
  input  logic               iRun,
  input  logic               iSync,
  multi_rate_divider_if.slave cfg,
  output logic [NUM_CH-1:0]  oEnable,
  output logic [NUM_CH-1:0]  oWave
);

  localparam int CH_W = ch_width(NUM_CH);

  logic readyQ;
  logic errQ;
  logic accept;
  logic chOk;

  // Sync owns the edge it is asserted on, so config is refused for that cycle.
  assign cfg.oCfgReady = readyQ & ~iSync;
  assign cfg.oCfgErr   = errQ;
  assign accept        = cfg.iCfgValid & cfg.oCfgReady;
  assign chOk          = 32'(cfg.iCfgCh) < NUM_CH;

  always_ff @(posedge iClock) begin
    if (iReset) begin
      readyQ <= 1'b0;
      errQ   <= 1'b0;
    end else begin
      readyQ <= 1'b1;
      errQ   <= accept & ~chOk;
    end
  end

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    logic wrEn;
    assign wrEn = accept && chOk && (cfg.iCfgCh == CH_W'(c));

    rate_div_channel #(
      .CNT_W     (CNT_W),
      .RESET_DIV (CNT_W'(RESET_DIV))
    ) u_ch (
      .iClock   (iClock),
      .iReset   (iReset),
      .iRun     (iRun),
      .iSync    (iSync),
      .iWrEn    (wrEn),
      .iWrDefer (cfg.iCfgDefer),
      .iWrDiv   (cfg.iCfgDiv),
      .oEnable  (oEnable[c]),
      .oWave    (oWave[c])
    );
  end

endmodule
